sa_skew_feeder: RTL and testbench
=================================

# sa_skew_feeder

Input-side feeder for the systolic array: accepts one PE_SIZE-wide vector per cycle from the input buffer over a valid/ready stream and drives it into the array diagonally skewed. Lane k is delayed k cycles relative to lane 0, with a per-lane enable that travels with the data. It is the transmitter of the staggered per-row enable pattern that the psum accumulator consumes at the array's far edge. It counts vectors per tile, drains the skew pipeline, and pulses completion.

## Interface
- PE_SIZE, 4, number of array rows/lanes
- DATA_WIDTH, 8, bits per lane element
- ROW_NUM, 294, vectors per tile (counter limit, ≥1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  begin a tile; sampled only in IDLE
- vec_i  input  DATA_WIDTH*PE_SIZE  input vector; lane k = vec_i[DATA_WIDTH*k +: DATA_WIDTH]
- vec_valid_i  input  1  vec_i valid
- vec_ready_o  output  1  feeder accepts vec_i this cycle
- skew_data_o  output  DATA_WIDTH*PE_SIZE  skewed lane data to array rows, same lane packing
- skew_en_o  output  PE_SIZE  per-lane element-valid to array rows
- busy_o  output  1  state ≠ IDLE
- done_o  output  1  one-cycle pulse at tile completion

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE: vec_ready_o=0. start_i=1 → STREAM, vector counter cleared.
- STREAM: vec_ready_o=1. Accept = vec_valid_i & vec_ready_o. Each accept increments the counter. The accept that brings the count to ROW_NUM → DRAIN.
- DRAIN: vec_ready_o=0. Lasts exactly PE_SIZE cycles, timed by a drain counter. Then → DONE.
- DONE: done_o=1 for one cycle, then → IDLE.
- start_i outside IDLE is ignored. No abort other than rst.
- Per lane k, the pair {en, data} passes through 1+k register stages:
  - Stage-0 input is {accept, vec_i lane k} when accept=1.
  - Otherwise it is {0, 0}, so bubbles propagate diagonally.
- Data is zero whenever the lane enable is 0. The array never sees stale values.
- Vector counter width: $clog2(ROW_NUM+1). Drain counter width: $clog2(PE_SIZE+1). No arithmetic on data; lanes pass through bit-exact.

## Timing
- Reset (rst=1 at an edge): after that edge, state=IDLE, both counters=0, and every pipeline stage is cleared. Consequently:
  - vec_ready_o=0, busy_o=0, done_o=0.
  - skew_en_o=0, skew_data_o=0.
- rst mid-tile discards all in-flight elements with no partial done_o.
- start_i seen at edge e → STREAM after e. The earliest accept is in the cycle after e.
- Accept in cycle t → lane k en/data high in cycle t+1+k.
- Last accept in cycle tL:
  - DRAIN covers cycles tL+1 … tL+PE_SIZE.
  - Lane PE_SIZE-1 emits the last element in cycle tL+PE_SIZE.
  - done_o=1 in cycle tL+PE_SIZE+1.
  - IDLE from cycle tL+PE_SIZE+2.
- start_i during DONE is ignored. Minimum gap between tiles: start sampled in the first IDLE cycle.
- vec_valid_i may drop at any cycle in STREAM. The counter holds, and skew timing is preserved per element.

## Structure
- Shared package holds:
  - PE_SIZE and DATA_WIDTH defaults, common with the accumulator and array.
  - The feeder state enum: IDLE, STREAM, DRAIN, DONE.
- Sub-module skew_delay_line (params DEPTH, WIDTH): a synchronously reset shift register of {en, data}. It is instantiated per lane with DEPTH=1+k via generate.
- The FSM and counters live in sa_skew_feeder.

## Test plan
- Reset: hold rst 3 cycles with random inputs → all outputs 0 and busy_o=0 every cycle, including the cycle after release.
- Basic tile (PE_SIZE=4, ROW_NUM=3):
  - Stimulus: start at cycle 0; vectors 0x04030201, 0x08070605, 0x0C0B0A09 accepted in cycles 1–3.
  - Expected lanes: lane0 en in cycles 2–4 with data 01,05,09; lane3 en in cycles 5–7 with data 04,08,0C.
  - Expected control: done_o in cycle 8; busy_o low from cycle 9.
- Bubble: same tile with vec_valid_i=0 in cycle 2 → every lane shows a one-cycle en=0, data=0 gap, shifted k cycles per lane. Counter finishes one cycle later; done_o in cycle 9.
- Ignored start: pulse start_i during STREAM and DRAIN → no counter restart, done_o timing unchanged. vec_ready_o=0 throughout DRAIN.
- Reset mid-tile: rst in cycle 2 of the basic tile → all outputs 0 from cycle 3, no done_o. A fresh start then completes the full 3-vector tile with the basic-tile timing.
- Back-to-back tiles: start asserted continuously → the second tile's STREAM begins the cycle after the first IDLE cycle. Two done_o pulses, each preceded by exactly ROW_NUM enable pulses per lane.

Source files
------------

// File: rtl/sa_skew_feeder_pkg.sv
// Shared definitions for the systolic-array input side.
// Holds the array geometry defaults shared with the accumulator and the
// array itself, and the state encoding of the skew feeder FSM.
package sa_skew_feeder_pkg;

    localparam int unsigned PE_SIZE_DEF    = 4;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/sa_skew_feeder_skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register of one lane's {en, data} word.
// Every stage clears on synchronous reset, so a reset discards anything in
// flight.
//   clk  : clock
//   rst  : synchronous, active-high reset
//   din  : stage-0 input word
//   dout : word leaving the last stage (DEPTH cycles after din)
module skew_delay_line
    import sa_skew_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = DATA_WIDTH_DEF + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: takes one PE_SIZE-lane vector per cycle over a valid/ready
// stream and drives it into the array diagonally skewed (lane k delayed k
// cycles behind lane 0), with a per-lane enable travelling alongside the data.
// Counts ROW_NUM vectors per tile, drains the skew pipeline, pulses done.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : begin a tile (looked at only in IDLE)
//   vec_i        : input vector, lane k = vec_i[DATA_WIDTH*k +: DATA_WIDTH]
//   vec_valid_i  : vec_i valid
//   vec_ready_o  : vector accepted this cycle when also valid
//   skew_data_o  : skewed lane data, same packing as vec_i
//   skew_en_o    : per-lane element valid
//   busy_o       : not IDLE
//   done_o       : one-cycle pulse at tile completion
module sa_skew_feeder
    import sa_skew_feeder_pkg::*;
#(
    parameter int unsigned PE_SIZE    = PE_SIZE_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ROW_NUM    = 294
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] vec_i,
    input  logic                          vec_valid_i,
    output logic                          vec_ready_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0] skew_data_o,
    output logic [PE_SIZE-1:0]            skew_en_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned VCW = $clog2(ROW_NUM + 1);
    localparam int unsigned DCW = $clog2(PE_SIZE + 1);

    feeder_state_t  state, state_nxt;
    logic [VCW-1:0] vec_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           accept;
    logic           last_vec;
    logic           drain_end;

    assign accept    = vec_valid_i & vec_ready_o;
    assign last_vec  = (vec_cnt == VCW'(ROW_NUM - 1));
    assign drain_end = (drain_cnt == DCW'(PE_SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        vec_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                vec_ready_o = 1'b1;
                if (accept && last_vec) begin
                    state_nxt = DRAIN;
                end
            end
            // PE_SIZE cycles: the last lane needs that long to emit the final element
            DRAIN: begin
                if (drain_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        vec_cnt <= '0;
                    end
                    drain_cnt <= '0;
                end
                STREAM: begin
                    if (accept) begin
                        vec_cnt <= vec_cnt + VCW'(1);
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DCW'(1);
                end
                default: begin
                    drain_cnt <= '0;
                end
            endcase
        end
    end

    // Non-accept cycles inject {0,0} so bubbles travel down the diagonal and
    // the array never sees stale data.
    for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
        logic [DATA_WIDTH:0] lane_in;
        logic [DATA_WIDTH:0] lane_out;

        assign lane_in = accept ? {1'b1, vec_i[DATA_WIDTH*k +: DATA_WIDTH]} : '0;

        skew_delay_line #(
            .DEPTH (k + 1),
            .WIDTH (DATA_WIDTH + 1)
        ) u_delay (
            .clk  (clk),
            .rst  (rst),
            .din  (lane_in),
            .dout (lane_out)
        );

        assign skew_en_o[k]                           = lane_out[DATA_WIDTH];
        assign skew_data_o[DATA_WIDTH*k +: DATA_WIDTH] = lane_out[DATA_WIDTH-1:0];
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder with PE_SIZE=4, DATA_WIDTH=8, ROW_NUM=3.
// Lane outputs and done_o are scoreboarded: each expected accept pushes one
// entry per lane for cycle t+1+k, each tile pushes its done cycle; a negedge
// monitor compares every cycle. Tasks check ready/busy inline.
module tb_sa_skew_feeder;

    localparam int PE = 4;
    localparam int DW = 8;
    localparam int RN = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [DW*PE-1:0] vec_i;
    logic            vec_valid_i;
    logic            vec_ready_o;
    logic [DW*PE-1:0] skew_data_o;
    logic [PE-1:0]   skew_en_o;
    logic            busy_o;
    logic            done_o;

    sa_skew_feeder #(
        .PE_SIZE    (PE),
        .DATA_WIDTH (DW),
        .ROW_NUM    (RN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .vec_i       (vec_i),
        .vec_valid_i (vec_valid_i),
        .vec_ready_o (vec_ready_o),
        .skew_data_o (skew_data_o),
        .skew_en_o   (skew_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    typedef struct {
        int         cyc;
        int         lane;
        logic [7:0] data;
    } lane_exp_t;

    lane_exp_t lane_q[$];
    int        done_q[$];

    logic [31:0] basic_v[3];
    initial begin
        basic_v[0] = 32'h04030201;
        basic_v[1] = 32'h08070605;
        basic_v[2] = 32'h0C0B0A09;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [31:0] v);
        lane_exp_t e;
        for (int k = 0; k < PE; k++) begin
            e.cyc  = cyc + 1 + k;
            e.lane = k;
            e.data = v[8*k +: 8];
            lane_q.push_back(e);
        end
    endtask

    // Scoreboard monitor: expected lanes default to en=0, data=0.
    logic [PE-1:0]    m_en;
    logic [DW*PE-1:0] m_dat;
    logic             m_done;
    always @(negedge clk) begin
        if (mon_on) begin
            m_en  = '0;
            m_dat = '0;
            foreach (lane_q[i]) begin
                if (lane_q[i].cyc == cyc) begin
                    m_en[lane_q[i].lane]           = 1'b1;
                    m_dat[8*lane_q[i].lane +: 8]   = lane_q[i].data;
                end
            end
            total++;
            if (skew_en_o !== m_en || skew_data_o !== m_dat) begin
                bad++;
                $display("FAIL lanes cyc=%0d: got en=%b data=%h, want en=%b data=%h",
                         cyc, skew_en_o, skew_data_o, m_en, m_dat);
            end
            m_done = (done_q.size() > 0) && (done_q[0] == cyc);
            total++;
            if (done_o !== m_done) begin
                bad++;
                $display("FAIL done cyc=%0d: got %b want %b", cyc, done_o, m_done);
            end
            if (m_done) void'(done_q.pop_front());
            for (int i = lane_q.size() - 1; i >= 0; i--) begin
                if (lane_q[i].cyc <= cyc) lane_q.delete(i);
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_i = 1'($urandom); vec_valid_i = 1'($urandom); vec_i = $urandom;
            tick();
            mon_on = 1'b1;
            total++;
            if ({vec_ready_o, busy_o, done_o, skew_en_o, skew_data_o} !== '0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d: got rdy=%b busy=%b done=%b en=%b data=%h want all 0",
                         cyc, vec_ready_o, busy_o, done_o, skew_en_o, skew_data_o);
            end
            start_i = 1'($urandom); vec_valid_i = 1'($urandom); vec_i = $urandom;
        end
        rst = 1'b0; start_i = 1'b0; vec_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({vec_ready_o, busy_o, done_o, skew_en_o, skew_data_o} !== '0) begin
                bad++;
                $display("FAIL reset_release cyc=%0d: got rdy=%b busy=%b done=%b en=%b want all 0",
                         cyc, vec_ready_o, busy_o, done_o, skew_en_o);
            end
            tick();
        end
    endtask

    task automatic test_basic;
        int  base = cyc;
        int  n = 0;
        bit  v;
        for (int rel = 0; rel <= 10; rel++) begin
            start_i = (rel == 0);
            v = (rel >= 1 && rel <= 3);
            vec_valid_i = v;
            vec_i = v ? basic_v[n] : $urandom;
            if (v) begin push_vec(basic_v[n]); n++; end
            if (rel == 0) done_q.push_back(base + 8);
            total++;
            if (vec_ready_o !== v) begin
                bad++;
                $display("FAIL basic_ready rel=%0d: got %b want %b", rel, vec_ready_o, v);
            end
            total++;
            if (busy_o !== (rel >= 1 && rel <= 8)) begin
                bad++;
                $display("FAIL basic_busy rel=%0d: got %b want %b", rel, busy_o, (rel >= 1 && rel <= 8));
            end
            tick();
        end
        start_i = 1'b0; vec_valid_i = 1'b0;
    endtask

    task automatic test_bubble;
        int  base = cyc;
        int  n = 0;
        bit  v;
        for (int rel = 0; rel <= 11; rel++) begin
            start_i = (rel == 0);
            v = (rel == 1 || rel == 3 || rel == 4);
            vec_valid_i = v;
            vec_i = v ? basic_v[n] : $urandom;
            if (v) begin push_vec(basic_v[n]); n++; end
            if (rel == 0) done_q.push_back(base + 9);
            total++;
            if (vec_ready_o !== (rel >= 1 && rel <= 4)) begin
                bad++;
                $display("FAIL bubble_ready rel=%0d: got %b want %b", rel, vec_ready_o, (rel >= 1 && rel <= 4));
            end
            total++;
            if (busy_o !== (rel >= 1 && rel <= 9)) begin
                bad++;
                $display("FAIL bubble_busy rel=%0d: got %b want %b", rel, busy_o, (rel >= 1 && rel <= 9));
            end
            tick();
        end
        start_i = 1'b0; vec_valid_i = 1'b0;
    endtask

    task automatic test_ignored_start;
        int  base = cyc;
        int  n = 0;
        bit  v;
        for (int rel = 0; rel <= 10; rel++) begin
            start_i = (rel == 0 || rel == 2 || rel == 5 || rel == 6 || rel == 8);
            v = (rel >= 1 && rel <= 3);
            vec_valid_i = v;
            vec_i = v ? basic_v[n] : $urandom;
            if (v) begin push_vec(basic_v[n]); n++; end
            if (rel == 0) done_q.push_back(base + 8);
            total++;
            if (vec_ready_o !== v) begin
                bad++;
                $display("FAIL ignstart_ready rel=%0d: got %b want %b", rel, vec_ready_o, v);
            end
            total++;
            if (busy_o !== (rel >= 1 && rel <= 8)) begin
                bad++;
                $display("FAIL ignstart_busy rel=%0d: got %b want %b", rel, busy_o, (rel >= 1 && rel <= 8));
            end
            tick();
        end
        start_i = 1'b0; vec_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        // cycle 0: start, cycle 1: accept first vector, cycle 2: reset
        start_i = 1'b1; vec_valid_i = 1'b0;
        tick();
        start_i = 1'b0; vec_valid_i = 1'b1; vec_i = basic_v[0];
        push_vec(basic_v[0]);
        tick();
        rst = 1'b1; vec_i = basic_v[1];
        for (int i = lane_q.size() - 1; i >= 0; i--) begin
            if (lane_q[i].cyc > cyc) lane_q.delete(i);
        end
        total++;
        if (vec_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ready_before: got %b want 1", vec_ready_o);
        end
        tick();
        rst = 1'b0; vec_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (busy_o !== 1'b0 || vec_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_idle i=%0d: got busy=%b rdy=%b want 0 0", i, busy_o, vec_ready_o);
            end
            tick();
        end
        test_basic();
    endtask

    task automatic test_back_to_back;
        int base = cyc;
        int cnt[PE];
        bit acc;
        bit exp_busy;
        logic [31:0] v;
        foreach (cnt[k]) cnt[k] = 0;
        done_q.push_back(base + 8);
        done_q.push_back(base + 17);
        for (int rel = 0; rel <= 19; rel++) begin
            foreach (cnt[k]) cnt[k] += int'(skew_en_o[k]);
            if (rel == 9 || rel == 18) begin
                foreach (cnt[k]) begin
                    total++;
                    if (cnt[k] !== RN) begin
                        bad++;
                        $display("FAIL b2b_en_count rel=%0d lane=%0d: got %0d want %0d", rel, k, cnt[k], RN);
                    end
                    cnt[k] = 0;
                end
            end
            start_i = (rel <= 17);
            vec_valid_i = 1'b1;
            v = $urandom;
            vec_i = v;
            acc = (rel >= 1 && rel <= 3) || (rel >= 10 && rel <= 12);
            if (acc) push_vec(v);
            exp_busy = !(rel == 0 || rel == 9 || rel >= 18);
            total++;
            if (vec_ready_o !== acc) begin
                bad++;
                $display("FAIL b2b_ready rel=%0d: got %b want %b", rel, vec_ready_o, acc);
            end
            total++;
            if (busy_o !== exp_busy) begin
                bad++;
                $display("FAIL b2b_busy rel=%0d: got %b want %b", rel, busy_o, exp_busy);
            end
            tick();
        end
        start_i = 1'b0; vec_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; vec_valid_i = 1'b0; vec_i = '0;
        test_reset();
        test_basic();
        test_bubble();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        repeat (6) tick();
        total++;
        if (lane_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got lanes=%0d done=%0d pending, want 0 0",
                     lane_q.size(), done_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
